// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing defaults and helpers for the sync generator, renderer and game logic.
package vga_sync_gen_pkg;

  // 640x480@60Hz defaults (pixel units horizontally, line units vertically)
  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  // Derived defaults
  localparam int unsigned H_TOTAL_DEF  = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF  = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int unsigned HS_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
  localparam int unsigned VS_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

  // Coordinates are 10-bit unsigned; both totals must fit in 1024.
  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] coord_t;

  // Half-open window test lo <= v < hi, used for the sync pulses.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_mod_counter.sv
// Modulo counter: counts 0..MAX on enabled cycles and wraps by compare, not overflow.
module mod_counter #(
  parameter int unsigned MAX = 799
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] count,
  output logic       wrap
);

  localparam logic [9:0] MAX_C = 10'(MAX);

  logic [9:0] count_q, count_d;

  assign count = count_q;
  assign wrap  = en && (count_q == MAX_C);

  // Next count: hold, increment, or return to zero at MAX
  always_comb begin
    count_d = count_q;
    if (en) count_d = wrap ? '0 : count_q + 10'd1;
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel enable, coordinates, syncs, visible flag and frame pulse.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic       clk50mhz,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  logic   tick_q;
  coord_t h_cnt, v_cnt;
  logic   h_wrap, v_wrap;
  coord_t h_nxt, v_nxt;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   video_on_q, video_on_d;
  logic   frame_tick_q, frame_tick_d;

  // Column counter advances once per pixel (every other clk)
  mod_counter #(.MAX(H_TOTAL - 1)) u_h (
    .clk   (clk50mhz),
    .reset (reset),
    .en    (tick_q),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  // Line counter advances on the column wrap edge
  mod_counter #(.MAX(V_TOTAL - 1)) u_v (
    .clk   (clk50mhz),
    .reset (reset),
    .en    (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  // Predict the counter values after this edge so the registered flags line up with them
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (tick_q) h_nxt = h_wrap ? '0 : h_cnt + 10'd1;
    if (h_wrap) v_nxt = v_wrap ? '0 : v_cnt + 10'd1;
    hsync_d      = ~in_window(h_nxt, HS_START, HS_END);
    vsync_d      = ~in_window(v_nxt, VS_START, VS_END);
    video_on_d   = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    // A line-counter wrap means the next cycle is the first at (0,0) of a new frame
    frame_tick_d = v_wrap;
  end

  // Tick divider and output registers
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      tick_q       <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      tick_q       <= ~tick_q;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pixel_tick = tick_q;
  assign pixel_x    = h_cnt;
  assign pixel_y    = v_cnt;
  assign video_on   = video_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 timing and a tiny override, random resets,
// compared every cycle against an arithmetic model indexed by clocks since reset.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst;

  logic       d_tick, d_von, d_hs, d_vs, d_ft;
  logic [9:0] d_x, d_y;
  logic       s_tick, s_von, s_hs, s_vs, s_ft;
  logic [9:0] s_x, s_y;

  vga_sync_gen u_dut (
    .clk50mhz(clk), .reset(rst), .pixel_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
    .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .frame_tick(d_ft)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .clk50mhz(clk), .reset(rst), .pixel_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
    .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .frame_tick(s_ft)
  );

  int checks = 0;
  int fails  = 0;
  longint n = 0;     // clk edges since the last edge that sampled reset
  bit armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%0d exp=%0d n=%0d", tag, obs, exp, n);
    end
  endtask

  typedef struct packed {
    logic       tick;
    logic [9:0] x, y;
    logic       von, hs, vs, ft;
  } ref_t;

  // Reference: each pixel lasts 2 clk, raster order, frame = 2*HT*VT clk.
  function automatic ref_t model(input longint k, input int hd, input int hf, input int hw,
                                 input int hb, input int vd, input int vf, input int vw,
                                 input int vb);
    ref_t   r;
    longint ht = hd + hf + hw + hb;
    longint vt = vd + vf + vw + vb;
    longint p  = k / 2;
    longint x  = p % ht;
    longint y  = (p / ht) % vt;
    r.tick = (k % 2) == 1;
    r.x    = 10'(x);
    r.y    = 10'(y);
    if (k == 0) begin
      r.von = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.ft = 1'b0;
    end else begin
      r.von = (x < hd) && (y < vd);
      r.hs  = !((x >= hd + hf) && (x < hd + hf + hw));
      r.vs  = !((y >= vd + vf) && (y < vd + vf + vw));
      r.ft  = (k % (2 * ht * vt)) == 0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      n     <= 0;
      armed <= 1'b1;
    end else begin
      n <= n + 1;
    end
  end

  // Event trackers for line/frame-level properties
  int     hs_run = 0;
  logic   d_hs_prev = 1'b1, d_von_prev = 1'b0;
  longint last_ft = -1;

  always @(negedge clk) begin
    ref_t rd, rs;
    if (armed) begin
      rd = model(n, 640, 16, 96, 48, 480, 10, 2, 33);
      rs = model(n, 8, 2, 2, 2, 4, 1, 1, 1);
      chk("d_tick", 32'(d_tick), 32'(rd.tick));
      chk("d_x",    32'(d_x),    32'(rd.x));
      chk("d_y",    32'(d_y),    32'(rd.y));
      chk("d_von",  32'(d_von),  32'(rd.von));
      chk("d_hs",   32'(d_hs),   32'(rd.hs));
      chk("d_vs",   32'(d_vs),   32'(rd.vs));
      chk("d_ft",   32'(d_ft),   32'(rd.ft));
      chk("s_tick", 32'(s_tick), 32'(rs.tick));
      chk("s_x",    32'(s_x),    32'(rs.x));
      chk("s_y",    32'(s_y),    32'(rs.y));
      chk("s_von",  32'(s_von),  32'(rs.von));
      chk("s_hs",   32'(s_hs),   32'(rs.hs));
      chk("s_vs",   32'(s_vs),   32'(rs.vs));
      chk("s_ft",   32'(s_ft),   32'(rs.ft));

      if (n == 0) begin
        hs_run  = 0;
        last_ft = -1;
      end else begin
        // hsync pulse: starts at 656, lasts 192 clk
        if (!d_hs && d_hs_prev) chk("hs_first_x", 32'(d_x), 32'd656);
        if (!d_hs) hs_run++;
        if (d_hs && !d_hs_prev) begin
          chk("hs_width", 32'(hs_run), 32'd192);
          chk("hs_rise_x", 32'(d_x), 32'd752);
          hs_run = 0;
        end
        // video_on falls at column 640 on visible lines
        if (!d_von && d_von_prev && d_y < 10'd480) chk("von_fall_x", 32'(d_x), 32'd640);
        // small-config frame_tick spacing and position
        if (s_ft) begin
          chk("ft_xy", {12'd0, s_x, s_y}, 32'd0);
          if (last_ft >= 0) chk("ft_period", 32'(n - last_ft), 32'd196);
          last_ft = n;
        end
      end
      d_hs_prev  = d_hs;
      d_von_prev = d_von;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    // Uninterrupted stretch covering two full default lines
    repeat (4000) @(negedge clk);
    // Random run lengths with short random reset pulses
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(20, 2500)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (2000) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
